// File: rtl/score_char_rom.sv
// Score banner text source: sequential double-dabble conversion of a binary score
// into committed decimal digits served through a registered char_xy -> char_code lookup.
// Optional SCORE_LEAD_BLANK_EN: render leading zero digits as spaces (LSD always shown).
module score_char_rom #(
    parameter int                    PREFIX_LEN = 6,
    parameter logic [8*PREFIX_LEN-1:0] PREFIX   = "SCORE ",
    parameter int                    DIGITS     = 5,
    parameter int                    VALUE_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] value,
    input  logic               update,
    output logic               busy,
    output logic               done,
    input  logic [7:0]         char_xy,
    output logic [6:0]         char_code
);

    // state   | meaning
    // IDLE    | waiting for an update request
    // LOAD    | saturation check, iteration counter load
    // SHIFT   | one add-3 / shift-left step per cycle
    // COMMIT  | copy result into the displayed digit buffer

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    function automatic logic [63:0] calc_limit(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    localparam logic [63:0] SAT_LIMIT = calc_limit(DIGITS);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t             state;
    logic [VALUE_W-1:0] bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   disp_q;
    logic [VALUE_W-1:0] pend_val;
    logic               pend;
    logic               sat;
    logic [CNT_W-1:0]   cnt;
    logic [6:0]         next_code;
    logic [3:0]         dig;
    logic [3:0]         col;
    logic [3:0]         row;
`ifdef SCORE_LEAD_BLANK_EN
    logic               lead;
`endif

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            disp_q   <= '0;
            pend_val <= '0;
            pend     <= 1'b0;
            sat      <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (update) begin
                        bin_q <= value;
                        bcd_q <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    sat   <= 64'(bin_q) > SAT_LIMIT;
                    cnt   <= CNT_W'(VALUE_W);
                    state <= SHIFT;
                    if (update) begin
                        pend_val <= value;
                        pend     <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= COMMIT;
                    if (update) begin
                        pend_val <= value;
                        pend     <= 1'b1;
                    end
                end
                COMMIT: begin
                    disp_q <= sat ? {DIGITS{4'h9}} : bcd_q;
                    done   <= 1'b1;
                    // a request arriving this very cycle is newer than any pending one
                    if (update || pend) begin
                        bin_q <= update ? value : pend_val;
                        bcd_q <= '0;
                        pend  <= 1'b0;
                        state <= LOAD;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign col = char_xy[3:0];
    assign row = char_xy[7:4];

    always_comb begin
        next_code = 7'h20;
        dig       = 4'd0;
`ifdef SCORE_LEAD_BLANK_EN
        lead      = 1'b1;
`endif
        if (row == 4'd0) begin
            for (int i = 0; i < PREFIX_LEN; i++) begin
                if (col == 4'(i)) next_code = PREFIX[8*(PREFIX_LEN-1-i) +: 7];
            end
            for (int i = 0; i < DIGITS; i++) begin
                dig = disp_q[4*(DIGITS-1-i) +: 4];
`ifdef SCORE_LEAD_BLANK_EN
                lead = lead && (dig == 4'd0);
                if (col == 4'(PREFIX_LEN + i))
                    next_code = (lead && (i != DIGITS - 1)) ? 7'h20 : {3'b011, dig};
`else
                if (col == 4'(PREFIX_LEN + i)) next_code = {3'b011, dig};
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) char_code <= 7'h20;
        else      char_code <= next_code;
    end

endmodule

// File: tb/tb_score_char_rom.sv
// Directed bench for score_char_rom: table-driven conversions on a 5-digit and a 4-digit
// instance, plus hand sequences for live sweeps, pending updates and mid-conversion reset.
module tb_score_char_rom;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        update = 1'b0;
    logic [15:0] value = '0;
    logic [7:0]  char_xy = '0;
    logic        busy, done, busy4, done4;
    logic [6:0]  char_code, code4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    score_char_rom dut (
        .clk(clk), .rst(rst), .value(value), .update(update),
        .busy(busy), .done(done), .char_xy(char_xy), .char_code(char_code)
    );

    score_char_rom #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .value(value), .update(update),
        .busy(busy4), .done(done4), .char_xy(char_xy), .char_code(code4)
    );

    typedef struct {
        logic [15:0] v;
        string       d5;
        string       d4;
    } vec_t;

    vec_t vecs[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_char(input int col, input string d);
        string pre = "SCORE ";
        int    n   = d.len();
        byte   b;
        bit    blank;
        if (col < 6) begin
            b = pre[col];
            return b[6:0];
        end
        if (col >= 6 + n) return 7'h20;
        blank = 1'b1;
        for (int i = 0; i <= col - 6; i++) if (d[i] != 8'h30) blank = 1'b0;
`ifdef SCORE_LEAD_BLANK_EN
        if (blank && (col - 6 != n - 1)) return 7'h20;
`endif
        b = d[col-6];
        return b[6:0];
    endfunction

    task automatic sweep(input string d5, input string d4);
        for (int c = 0; c < 16; c++) begin
            char_xy = 8'(c);
            tick();
            check($sformatf("sweep5 %s col%0d", d5, c), 32'(char_code), 32'(exp_char(c, d5)));
            check($sformatf("sweep4 %s col%0d", d4, c), 32'(code4), 32'(exp_char(c, d4)));
        end
        char_xy = 8'h17;
        tick();
        check("row1 digit col", 32'(char_code), 32'h20);
        char_xy = 8'hF0;
        tick();
        check("row15 prefix col", 32'(code4), 32'h20);
    endtask

    task automatic convert(input logic [15:0] v);
        value  = v;
        update = 1'b1;
        tick();
        update = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            check($sformatf("busy c%0d v%0d", c, v), 32'(busy), 32'd1);
            check($sformatf("done c%0d v%0d", c, v), 32'(done), 32'd0);
            tick();
        end
        check("done at c19", 32'(done), 32'd1);
        check("busy at c19", 32'(busy), 32'd0);
        check("done4 at c19", 32'(done4), 32'd1);
        check("busy4 at c19", 32'(busy4), 32'd0);
        tick();
        check("done one cycle", 32'(done), 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'd0,     "00000", "0000"};
        vecs[1] = '{16'd1234,  "01234", "1234"};
        vecs[2] = '{16'd9999,  "09999", "9999"};
        vecs[3] = '{16'd10000, "10000", "9999"};
        vecs[4] = '{16'd12345, "12345", "9999"};
        vecs[5] = '{16'd65535, "65535", "9999"};
        vecs[6] = '{16'd7,     "00007", "0007"};
        vecs[7] = '{16'd42,    "00042", "0042"};

        // reset state
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset code", 32'(char_code), 32'h20);
        check("reset code4", 32'(code4), 32'h20);
        rst = 1'b1;
        tick();
        sweep("00000", "0000");

        foreach (vecs[i]) begin
            convert(vecs[i].v);
            sweep(vecs[i].d5, vecs[i].d4);
        end

        // live sweep while converting 1234 -> 65000
        convert(16'd1234);
        value   = 16'd65000;
        update  = 1'b1;
        char_xy = 8'd6;
        tick();
        update = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            check($sformatf("live c%0d", k), 32'(char_code),
                  32'(exp_char(6 + (k - 1) % 5, (k - 1 >= 19) ? "65000" : "01234")));
            char_xy = 8'(6 + k % 5);
            tick();
        end

        // pending updates: 200 is overwritten by 300 before the first commit
        char_xy = 8'd8;
        value   = 16'd100;
        update  = 1'b1;
        tick();
        for (int c = 1; c <= 45; c++) begin
            check($sformatf("pend busy c%0d", c), 32'(busy), 32'(c <= 36));
            check($sformatf("pend done c%0d", c), 32'(done), 32'(c == 19 || c == 37));
            if (c >= 2)
                check($sformatf("pend col8 c%0d", c), 32'(char_code),
                      32'(exp_char(8, (c - 1 >= 37) ? "00300" : (c - 1 >= 19) ? "00100" : "65000")));
            update = (c == 5 || c == 7);
            if (c == 5) value = 16'd200;
            if (c == 7) value = 16'd300;
            tick();
        end
        sweep("00300", "0300");

        // update coinciding with COMMIT
        value  = 16'd5;
        update = 1'b1;
        tick();
        for (int c = 1; c <= 40; c++) begin
            check($sformatf("cmt busy c%0d", c), 32'(busy), 32'(c <= 36));
            check($sformatf("cmt done c%0d", c), 32'(done), 32'(c == 19 || c == 37));
            update = (c == 18);
            if (c == 18) value = 16'd6;
            tick();
        end
        sweep("00006", "0006");

        // reset mid-conversion with a pending request outstanding
        value  = 16'd5555;
        update = 1'b1;
        tick();
        for (int c = 1; c <= 9; c++) begin
            update = (c == 5);
            if (c == 5) value = 16'd4444;
            tick();
        end
        update = 1'b0;
        rst    = 1'b0;
        tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst code", 32'(char_code), 32'h20);
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            check($sformatf("post-rst idle c%0d", c), 32'(busy | done), 32'd0);
            tick();
        end
        sweep("00000", "0000");
        convert(16'd7);
        sweep("00007", "0007");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_char_rom.md
# score_char_rom

Dynamic text source for the score banner. It converts a binary score into decimal ASCII characters with a sequential double-dabble engine. It serves the characters through the same `char_xy -> char_code` lookup that `draw_rect_char` drives, so it sits directly upstream of `font_rom` in place of the static text ROM. A committed double buffer keeps the displayed digits stable while a new conversion is in flight.

## Interface
Parameters:
- PREFIX, "SCORE ": fixed ASCII prefix, left-aligned at column 0.
- PREFIX_LEN, 6: number of characters in PREFIX.
- DIGITS, 5: number of decimal digits shown after the prefix.
- VALUE_W, 16: width of the binary score input.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- value  in  VALUE_W  binary score; sampled only on an accepted update.
- update  in  1  request conversion of `value`; single-cycle pulse or level.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the new digits are committed.
- char_xy  in  8  character cell from the renderer: [3:0] column, [7:4] row.
- char_code  out  7  ASCII code for `char_xy`, registered.

Width rule: PREFIX_LEN + DIGITS <= 16.

## Operation
FSM states: IDLE, LOAD, SHIFT, COMMIT.
- **IDLE**
  - `update`=1 captures `value` into the shift register, clears the BCD register (4*DIGITS bits) and goes to LOAD.
- **LOAD**
  - Compares the captured value against 10^DIGITS-1 and sets `sat` if greater.
  - Loads the iteration counter with VALUE_W.
  - Goes to SHIFT.
- **SHIFT**
  - Each cycle adds 3 to every BCD nibble >= 5, then shifts {bcd, bin} left by 1.
  - Decrements the counter; after VALUE_W shifts goes to COMMIT.
- **COMMIT**
  - Writes the display digits: BCD nibbles, or all 9s if `sat`.
  - Goes to IDLE if no update is pending, otherwise to LOAD with the pending value.
- **Update while busy**
  - `value` is latched into a pending register and a pending flag is set; a later request overwrites it, so the last value wins.
  - The conversion in flight is never aborted.
  - An update that coincides with COMMIT counts as pending.
- **Lookup**
  - Row != 0 gives 0x20 (space).
  - Column < PREFIX_LEN gives the PREFIX character.
  - PREFIX_LEN <= column < PREFIX_LEN+DIGITS gives 0x30 + digit, most significant digit first.
  - Column >= PREFIX_LEN+DIGITS gives 0x20.
- The lookup reads only the committed digits and never the working BCD register.

## Timing
- Reset values:
  - state IDLE; busy=0; done=0.
  - committed digits all 0; pending flag clear.
  - char_code = 7'h20.
- Lookup latency is 1 cycle: `char_code` in cycle n+1 reflects `char_xy` sampled in cycle n, matching `font_rom` addressing.
- Conversion, with `update` sampled at cycle 0:
  - LOAD at cycle 1, busy=1.
  - SHIFT at cycles 2..VALUE_W+1.
  - COMMIT at cycle VALUE_W+2.
  - done=1 and busy=0 at cycle VALUE_W+3, with the new digits visible to lookups sampled from that cycle.
  - With VALUE_W=16, done is at cycle 19.
- A back-to-back pending conversion keeps busy=1 continuously. done pulses after each COMMIT.
- Reset asserted mid-conversion:
  - Returns to IDLE immediately and clears busy, done and the pending flag.
  - The committed digits return to 0; no partial result is ever committed.

## Configuration
- SCORE_LEAD_BLANK_EN defined:
  - Leading zero digits are output as 0x20.
  - The least significant digit is always shown, so 0 renders as "SCORE     0".
  - Blanking is evaluated from the committed digits at lookup time, within the same 1-cycle latency.
- SCORE_LEAD_BLANK_EN undefined: all DIGITS positions are shown zero-padded, so 0 renders as "SCORE 00000".

## Test plan
Defaults apply: PREFIX "SCORE ", DIGITS=5, VALUE_W=16, macro undefined.
- After reset, sweep column 0..15 on row 0 -> "SCORE 00000" followed by 5×0x20; busy=0, done=0.
- update with value=1234 -> busy high in cycles 1..18, done pulse at cycle 19; columns 6..10 read 0x30,0x31,0x32,0x33,0x34.
- Sweep columns continuously during a conversion from 1234 to 65000 -> columns read "01234" until cycle 19, then "65000"; no mixed digits are ever seen.
- update 100 at cycle 0, then updates 200 and 300 at cycles 5 and 7 -> two done pulses; final display "00300"; 200 is never committed.
- With DIGITS=4, value=12345 -> display "9999"; with SCORE_LEAD_BLANK_EN defined, value=42 -> columns 6..10 read "   42".
- Reset asserted at cycle 10 of a conversion -> busy=0 next cycle and the display reads "00000"; a following update of 7 gives "00007".
